// File: rtl/gf_pkg.sv
// Shared GF(2^8) definitions for the divide engine: field constants, FSM states, xtime.
package gf_pkg;

    localparam int GF_W       = 8;
    localparam int MUL_CYCLES = 8;
    // Low byte of x^8+x^4+x^3+x^2+1; the x^8 term is implied by the shifted-out MSB.
    localparam logic [GF_W-1:0] GF_POLY = 8'h1D;

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        MUL,
        FIN,
        DONE
    } gf_state_e;

    function automatic logic [GF_W-1:0] xtime(input logic [GF_W-1:0] v);
        return {v[GF_W-2:0], 1'b0} ^ (v[GF_W-1] ? GF_POLY : '0);
    endfunction

endpackage

// File: rtl/gf_div_engine_if.sv
// Operand/result handshake bundle for gf_div_engine.
interface gf_div_engine_if;
    import gf_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [GF_W-1:0] a;
    logic [GF_W-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [GF_W-1:0] q;
    logic            dz;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, dz
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, dz
    );

endinterface

// File: rtl/gf_mul_serial.sv
// Bit-serial MSB-first GF(2^8) multiplier, MUL_CYCLES cycles per product.
// The start cycle already performs the first step, so back-to-back products add no idle cycles.
module gf_mul_serial
    import gf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [GF_W-1:0] x,
    input  logic [GF_W-1:0] y,
    output logic            busy,
    output logic            done,
    output logic [GF_W-1:0] p
);

    logic [2:0]      cnt;
    logic [2:0]      bit_idx;
    logic [GF_W-1:0] part;
    logic [GF_W-1:0] part_nxt;
    logic            active;
    logic            first;

    assign first    = start && !busy;
    assign active   = first || busy;
    assign bit_idx  = 3'(MUL_CYCLES - 1) - cnt;
    assign part_nxt = xtime(first ? '0 : part) ^ (y[bit_idx] ? x : '0);
    assign done     = active && (cnt == 3'(MUL_CYCLES - 1));
    // Valid in the done cycle; the caller captures it on that edge.
    assign p        = part_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
            part <= '0;
        end else if (active) begin
            part <= part_nxt;
            cnt  <= cnt + 3'd1;
            busy <= !done;
        end
    end

endmodule

// File: rtl/gf_div_engine.sv
// GF(2^8) divider: q = a * b^254 via seven square/multiply rounds on one shared serial multiplier.
// Optional GF_DIV_ZERO_CHECK_EN: b==0 short-circuits to DONE with dz=1.
module gf_div_engine
    import gf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    gf_div_engine_if.slave bus
);

    gf_state_e       state, nstate;
    logic [GF_W-1:0] opnd_a, sq, acc, q_r;
    logic [2:0]      iter;
    logic            accept;

    logic            mul_start, mul_busy, mul_done;
    logic [GF_W-1:0] mul_x, mul_y, mul_p;

    assign accept = bus.in_valid && (state == IDLE);

    gf_mul_serial u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .x     (mul_x),
        .y     (mul_y),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        mul_x     = '0;
        mul_y     = '0;
        mul_start = 1'b0;
        case (state)
            SQR: begin mul_x = sq;  mul_y = sq;     mul_start = !mul_busy; end
            MUL: begin mul_x = acc; mul_y = sq;     mul_start = !mul_busy; end
            FIN: begin mul_x = acc; mul_y = opnd_a; mul_start = !mul_busy; end
            default: ;
        endcase
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (bus.in_valid) begin
`ifdef GF_DIV_ZERO_CHECK_EN
                nstate = (bus.b == '0) ? DONE : SQR;
`else
                nstate = SQR;
`endif
            end
            SQR:  if (mul_done) nstate = MUL;
            MUL:  if (mul_done) nstate = (iter == 3'd7) ? FIN : SQR;
            FIN:  if (mul_done) nstate = DONE;
            DONE: if (bus.out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // sq walks b^2, b^4, ..., b^128; acc collects their product, then times a.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_a <= '0;
            sq     <= '0;
            acc    <= '0;
            q_r    <= '0;
            iter   <= '0;
        end else begin
            if (accept) begin
                opnd_a <= bus.a;
                sq     <= bus.b;
                acc    <= 8'h01;
                iter   <= 3'd1;
`ifdef GF_DIV_ZERO_CHECK_EN
                if (bus.b == '0) q_r <= '0;
`endif
            end
            if (mul_done) begin
                case (state)
                    SQR: sq <= mul_p;
                    MUL: begin
                        acc  <= mul_p;
                        iter <= iter + 3'd1;
                    end
                    FIN: begin
                        acc <= mul_p;
                        q_r <= mul_p;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef GF_DIV_ZERO_CHECK_EN
    logic dz_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         dz_r <= 1'b0;
        else if (accept) dz_r <= (bus.b == '0);
    end

    assign bus.dz = dz_r;
`else
    assign bus.dz = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.q         = q_r;

endmodule

// File: tb/tb_gf_div_engine.sv
// Directed-vector bench for gf_div_engine: table of divisions, back-pressure, reset abort, random sweep.
module tb_gf_div_engine;
    logic clk = 1'b0;
    logic rst;

    gf_div_engine_if bus();

    gf_div_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef GF_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif
    localparam int LAT      = 120;
    localparam int MAX_WAIT = 200;
    localparam int N_RAND   = 400;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic       dz;
    } vec_t;

    vec_t vecs[11];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r, xx, yy;
        r  = 8'h00;
        xx = x;
        yy = y;
        for (int i = 0; i < 8; i++) begin
            if (yy[0]) r = r ^ xx;
            xx = xx[7] ? ((xx << 1) ^ 8'h1D) : (xx << 1);
            yy = yy >> 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < MAX_WAIT) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < MAX_WAIT) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_q, input logic exp_dz);
        int lat;
        accept_op(a, b);
        wait_result(lat);
        check({name, "_lat"}, lat, (ZC && b == 8'h00) ? 0 : LAT);
        check({name, "_q"}, int'(bus.q), int'(exp_q));
        check({name, "_dz"}, int'(bus.dz), int'(exp_dz));
        @(posedge clk); #1;
    endtask

    initial begin
        int         lat;
        int         seen;
        logic [7:0] ra, rb;

        vecs[0]  = '{8'h01, 8'h02, 8'h8E, 1'b0};
        vecs[1]  = '{8'h1D, 8'h02, 8'h80, 1'b0};
        vecs[2]  = '{8'h80, 8'h02, 8'h40, 1'b0};
        vecs[3]  = '{8'h5A, 8'h01, 8'h5A, 1'b0};
        vecs[4]  = '{8'h00, 8'h53, 8'h00, 1'b0};
        vecs[5]  = '{8'h02, 8'h02, 8'h01, 1'b0};
        vecs[6]  = '{8'h8E, 8'h8E, 8'h01, 1'b0};
        vecs[7]  = '{8'h02, 8'h8E, 8'h04, 1'b0};
        vecs[8]  = '{8'h1D, 8'h80, 8'h02, 1'b0};
        vecs[9]  = '{8'h01, 8'h01, 8'h01, 1'b0};
        vecs[10] = '{8'h37, 8'h00, 8'h00, ZC};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_q", int'(bus.q), 0);
        check("rst_dz", int'(bus.dz), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz);

        // Hold the result, poke in_valid during DONE, then release on the same edge in_valid is high.
        bus.out_ready = 1'b0;
        accept_op(8'h1D, 8'h02);
        wait_result(lat);
        check("bp_lat", lat, LAT);
        bus.in_valid = 1'b1;
        bus.a        = 8'h80;
        bus.b        = 8'h02;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_q_stable", int'(bus.q), 8'h80);
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", int'(bus.out_valid), 0);
        check("bp_release_idle", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_late_accept", int'(bus.in_ready), 0);
        wait_result(lat);
        check("bp2_lat", lat, LAT);
        check("bp2_q", int'(bus.q), 8'h40);
        @(posedge clk); #1;

        // Reset 50 cycles into an operation.
        accept_op(8'h55, 8'h33);
        repeat (50) @(posedge clk);
        #1;
        check("abort_busy", int'(bus.in_ready), 0);
        rst = 1'b1;
        #1;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_q", int'(bus.q), 0);
        check("abort_dz", int'(bus.dz), 0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        do_op("post_abort", 8'h02, 8'h02, 8'h01, 1'b0);

        for (int i = 0; i < N_RAND; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            accept_op(ra, rb);
            wait_result(lat);
            check($sformatf("rand_a%0h_b%0h_lat", ra, rb), lat, LAT);
            check($sformatf("rand_a%0h_b%0h_qb", ra, rb), int'(gmul(bus.q, rb)), int'(ra));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
